// File: rtl/msrv32_pc_redirect_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : msrv32_pc_redirect_unit                                    |
// | Description : Next-PC selection with trap/branch redirect, stall-pending |
// |               capture, misaligned-target detection and flush generation. |
// |               Define MSRV32_REDIRECT_COUNT_EN to enable redirect counter.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module msrv32_pc_redirect_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             branch_taken_in,
  input  logic [WIDTH-1:0] iaddr_in,
  input  logic             trap_taken_in,
  input  logic [WIDTH-1:0] trap_address_in,
  input  logic             ahb_ready_in,
  output logic [WIDTH-1:0] i_addr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_4_out,
  output logic             flush_out,
  output logic             misaligned_instr_out,
  output logic [31:0]      redirect_count_out
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             misaligned_q, misaligned_d;
  logic             flush_q, flush_d;

  logic [WIDTH-1:0] pc_plus_4;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] fetch_addr;
  logic             branch_misaligned;
  logic             redirect_req;
  logic             redirect_load;

  always_comb begin
    pc_plus_4         = pc_q + WIDTH'(4);
    branch_target     = iaddr_in & ~WIDTH'(1);
    branch_misaligned = branch_taken_in && !trap_taken_in && branch_target[1];
    redirect_req      = trap_taken_in || (branch_taken_in && !branch_target[1]);
    redirect_target   = trap_taken_in ? trap_address_in : branch_target;

    state_d       = state_q;
    pending_d     = pending_q;
    misaligned_d  = 1'b0;
    redirect_load = 1'b0;
    fetch_addr    = pc_plus_4;

    if (state_q == ST_RUN) begin
      misaligned_d = branch_misaligned;
      if (redirect_req) begin
        fetch_addr = redirect_target;
        if (ahb_ready_in) begin
          redirect_load = 1'b1;
        end else begin
          pending_d = redirect_target;
          state_d   = ST_PENDING;
        end
      end
    end else begin
      // A trap arriving while stalled supersedes the held target immediately.
      fetch_addr = trap_taken_in ? trap_address_in : pending_q;
      pending_d  = fetch_addr;
      if (ahb_ready_in) begin
        redirect_load = 1'b1;
        state_d       = ST_RUN;
      end
    end

    pc_d    = ahb_ready_in ? fetch_addr : pc_q;
    flush_d = redirect_load;

    if (ms_riscv32_mp_rst_in) begin
      fetch_addr = BOOT_ADDRESS;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q      <= ST_RUN;
      pc_q         <= BOOT_ADDRESS;
      pending_q    <= '0;
      misaligned_q <= 1'b0;
      flush_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      misaligned_q <= misaligned_d;
      flush_q      <= flush_d;
    end
  end

`ifdef MSRV32_REDIRECT_COUNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (redirect_load) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign redirect_count_out = count_q;
`else
  assign redirect_count_out = 32'd0;
`endif

  assign i_addr_out           = fetch_addr;
  assign pc_out               = pc_q;
  assign pc_plus_4_out        = pc_plus_4;
  assign flush_out            = flush_q;
  assign misaligned_instr_out = misaligned_q;

endmodule
`default_nettype wire
